// File: rtl/booth_mult_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// booth_mult_seq_ctrl_if
// Operand-in / product-out handshake bundle for booth_mult_seq_ctrl.
//
// Signals:
//   in_valid  : operand pair valid (source -> controller)
//   in_ready  : controller can accept an operand pair
//   in_a      : multiplicand, 2's complement signed
//   in_b      : multiplier, unsigned
//   out_valid : out_prod holds a completed result
//   out_ready : consumer accepts result
//   out_prod  : captured signed product, 2*WIDTH bits
//
// Modports:
//   master : operand source / result consumer side
//   slave  : controller side
// ---------------------------------------------------------------------------
interface booth_mult_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   in_a;
    logic        [WIDTH-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] out_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/booth_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mult_seq_ctrl
// Operand-sequencing and result-capture controller for an 8-bit radix-4
// Booth signed x unsigned sequential multiplier. Accepts an operand pair,
// registers it onto the multiplier inputs, pulses load, waits ITER Booth
// iterations plus one settle cycle, then captures and presents the product.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (0 = reset)
//   bus      : operand/product handshake (booth_mult_seq_ctrl_if.slave)
//   mul_a    : registered multiplicand to multiplier
//   mul_b    : registered multiplier operand to multiplier
//   mul_load : one-cycle load strobe to multiplier
//   prod_in  : product from multiplier accumulator
//   busy     : high in any state except IDLE
//   done_cnt : completed-handshake counter, wraps 255 -> 0
//
// Configuration macro:
//   BOOTH_SEQ_B2B_EN : when defined, a new operand pair may be accepted in
//                      the same cycle the previous result is taken, skipping
//                      the IDLE cycle between operations.
// ---------------------------------------------------------------------------
module booth_mult_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int ITER  = 5,
    parameter int CNT_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    booth_mult_seq_ctrl_if.slave      bus,
    output logic signed [WIDTH-1:0]   mul_a,
    output logic        [WIDTH-1:0]   mul_b,
    output logic                      mul_load,
    input  logic        [2*WIDTH-1:0] prod_in,
    output logic                      busy,
    output logic        [7:0]         done_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             complete;

    // Next-state logic; accept/complete mark the handshake edges.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
`ifdef BOOTH_SEQ_B2B_EN
                    if (bus.in_valid) begin
                        accept    = 1'b1;
                        state_nxt = LOAD;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode from state only (the b2b build also follows
    // out_ready in DONE so a new pair is only taken alongside the result).
    always_comb begin
`ifdef BOOTH_SEQ_B2B_EN
        bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
`else
        bus.in_ready = (state == IDLE);
`endif
    end

    assign bus.out_valid = (state == DONE);
    assign mul_load      = (state == LOAD);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter: cleared during the load cycle, counts RUN cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Operand registers only change on an accepted pair, so they stay
    // stable from LOAD through the end of DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= bus.in_a;
            mul_b <= bus.in_b;
        end
    end

    // Product captured at the end of the settle cycle, held through DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_prod <= '0;
        end else if (state == CAPT) begin
            bus.out_prod <= prod_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_cnt <= 8'd0;
        end else if (complete) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end

endmodule

// File: doc/booth_mult_seq_ctrl.md
Name: booth_mult_seq_ctrl

Overview:
Operand-sequencing and result-capture controller for the 8-bit radix-4 Booth signed×unsigned sequential multiplier. Accepts operand pairs over a valid/ready handshake and registers them onto the multiplier's a/b inputs. Pulses the multiplier's load, counts its Booth iterations, then captures the 16-bit product and presents it over a valid/ready output handshake. It sits directly upstream and downstream of the multiplier, and one instance drives one multiplier.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH
ITER, 5, Booth digit iterations after load (zero-extended (WIDTH+2)-bit multiplier, 2 bits per cycle)
CNT_W, 3, iteration counter width; must satisfy 2**CNT_W >= ITER

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept an operand pair
in_a  in  WIDTH  multiplicand, 2's complement signed
in_b  in  WIDTH  multiplier, unsigned
mul_a  out  WIDTH  registered multiplicand to multiplier
mul_b  out  WIDTH  registered multiplier operand to multiplier
mul_load  out  1  one-cycle load strobe to multiplier
prod_in  in  2*WIDTH  product from multiplier accumulator
out_valid  out  1  out_prod holds a completed result
out_ready  in  1  consumer accepts result
out_prod  out  2*WIDTH  captured signed product
busy  out  1  high in any state except IDLE
done_cnt  out  8  completed-handshake counter, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. Counter, mul_a, mul_b, out_prod and done_cnt are cleared to 0. mul_load=0, out_valid=0, in_ready=1 on release. Reset mid-operation abandons the operation; no partial result is presented.
- All outputs are registered or decoded from state only. No combinational path from in_valid or out_ready to any output.
- FSM states: IDLE, LOAD, RUN, CAPT, DONE.
- IDLE: in_ready=1. When in_valid=1, the pair is accepted: mul_a<=in_a, mul_b<=in_b, next state LOAD.
- LOAD: mul_load=1 for exactly this one cycle. Counter<=0. Next state RUN.
- RUN: Counter increments each cycle. When counter==ITER-1, next state CAPT. RUN lasts exactly ITER cycles.
- CAPT: single settle cycle. At the end of this cycle, out_prod<=prod_in. Next state DONE.
- DONE: out_valid=1, and out_prod is held stable until accepted. When out_ready=1, done_cnt increments and next state is IDLE (base build).
- in_ready=0 in LOAD, RUN and CAPT. in_valid in those states is ignored; the source must hold the pair.
- mul_a and mul_b are held stable from LOAD through the end of DONE.
- Latency: accept edge to out_valid=1 is ITER+2 cycles (7 at defaults). Base throughput is one result per ITER+4 cycles when out_ready is held high.
- Arithmetic: the controller does no arithmetic. out_prod is a bit-exact copy of prod_in, interpreted as signed 2*WIDTH.
- done_cnt wraps modulo 256 with no flag.
- If out_ready is already high on the first DONE cycle, the result is accepted in that cycle and out_valid is high for exactly one cycle.

Optional Feature:
Macro BOOTH_SEQ_B2B_EN.
- Defined: in DONE, in_ready=out_ready. If out_ready=1 and in_valid=1 in the same cycle, the result completes (done_cnt++), the new pair is captured, and the next state is LOAD, skipping IDLE. Throughput becomes one result per ITER+3 cycles.
- Not defined: in_ready=0 in DONE, and one IDLE cycle always separates operations.

Test Plan:
- Reset then in_a=0xFD(-3), in_b=200 with out_ready=1 -> mul_load high exactly on the cycle after accept; out_valid rises 7 cycles after accept; out_prod=0xFDA8 (-600); done_cnt=1.
- in_a=0x80(-128), in_b=0xFF with out_ready=0 for 10 cycles -> out_prod=0x8080 (-32640) held stable; out_valid stays 1 and in_ready stays 0 until out_ready, then IDLE.
- in_valid asserted during RUN with a different pair -> ignored; mul_a/mul_b unchanged; first result still correct (0x7F×0x02=0x00FE).
- Assert rst=0 during RUN (counter=2) -> immediately IDLE, all outputs 0, no out_valid; the next op 0x05×0x03 returns 0x000F.
- 256 back-to-back ops with in_valid and out_ready held at 1 -> done_cnt wraps to 0. Spacing between results is 9 cycles without BOOTH_SEQ_B2B_EN and 8 with it, and no operand is dropped.
- Directed corners with the multiplier attached -> 0x00×0xFF=0x0000; 0x7F×0xFF=0x7E81; 0xFF×0x01=0xFFFF.
